// File: rtl/ysyx_25040111_lsu_pkg.sv
// Shared encodings for the LSU: FSM states, AXI burst/size/resp constants,
// access-mask encoding and access-fault cause codes.
package ysyx_25040111_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WREQ  = 3'd3,
    ST_WRESP = 3'd4
  } lsu_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_B     = 3'd0;
  localparam logic [2:0] AXI_SIZE_H     = 3'd1;
  localparam logic [2:0] AXI_SIZE_W     = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b11;

  localparam logic [3:0] ERR_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] ERR_STORE_FAULT = 4'd7;

  // Cache refills always move whole words regardless of the requested mask.
  function automatic logic [2:0] mask_to_size(input logic [1:0] mask, input logic burst);
    logic [2:0] size;
    if (burst) begin
      size = AXI_SIZE_W;
    end else begin
      case (mask)
        MASK_B:  size = AXI_SIZE_B;
        MASK_H:  size = AXI_SIZE_H;
        default: size = AXI_SIZE_W;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_align.sv
// Combinational lane alignment: read extract/extend and write shift/strobe.
module ysyx_25040111_lsu_align
  import ysyx_25040111_lsu_pkg::*;
#(
  parameter int LANE_W = 32
) (
  input  logic [1:0]          i_rlo,
  input  logic [1:0]          i_rmask,
  input  logic                i_rsign,
  input  logic                i_rburst,
  input  logic [LANE_W-1:0]   i_rdata,
  output logic [LANE_W-1:0]   o_rdata,
  input  logic [1:0]          i_wlo,
  input  logic [1:0]          i_wmask,
  input  logic [LANE_W-1:0]   i_wdata,
  output logic [LANE_W-1:0]   o_wdata,
  output logic [LANE_W/8-1:0] o_wstrb
);

  logic [4:0]            w_rshamt;
  logic [15:0]           w_rshift;
  logic                  w_bext;
  logic                  w_hext;
  logic [LANE_W/8-1:0]   w_strb_base;

  assign w_rshamt = {i_rlo, 3'b000};
  assign w_rshift = 16'(i_rdata >> w_rshamt);
  assign w_bext   = i_rsign & w_rshift[7];
  assign w_hext   = i_rsign & w_rshift[15];

  always_comb begin
    o_rdata = i_rdata;
    if (!i_rburst) begin
      case (i_rmask)
        MASK_B:  o_rdata = {{(LANE_W-8){w_bext}}, w_rshift[7:0]};
        MASK_H:  o_rdata = {{(LANE_W-16){w_hext}}, w_rshift[15:0]};
        default: o_rdata = i_rdata;
      endcase
    end
  end

  always_comb begin
    case (i_wmask)
      MASK_B:  w_strb_base = (LANE_W/8)'(1);
      MASK_H:  w_strb_base = (LANE_W/8)'(3);
      default: w_strb_base = '1;
    endcase
  end

  // Misaligned halves/words are not split: bits shifted past the lane are dropped.
  assign o_wstrb = w_strb_base << i_wlo;
  assign o_wdata = i_wdata << {i_wlo, 3'b000};

endmodule

// File: rtl/ysyx_25040111_lsu.sv
// LSU: turns arbiter lsu_* read/write requests into AXI4 master transactions.
// Optional macro YSYX_25040111_LSU_RESP_CHK_EN enables resp/id/rlast fault reporting.
module ysyx_25040111_lsu
  import ysyx_25040111_lsu_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int LANE_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lsu_rvalid,
  output logic              lsu_rready,
  input  logic [31:0]       lsu_raddr,
  input  logic [7:0]        lsu_rlen,
  input  logic              lsu_burst,
  input  logic              lsu_rsign,
  input  logic [1:0]        lsu_rmask,
  output logic [LANE_W-1:0] lsu_rdata,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  input  logic [31:0]       lsu_waddr,
  input  logic [LANE_W-1:0] lsu_wdata,
  input  logic [1:0]        lsu_wmask,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       awaddr,
  output logic [ID_W-1:0]   awid,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              wvalid,
  input  logic              wready,
  output logic [LANE_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  input  logic [ID_W-1:0]   bid,
  output logic              arvalid,
  input  logic              arready,
  output logic [31:0]       araddr,
  output logic [ID_W-1:0]   arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [LANE_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid,
  output logic              lsu_err,
  output logic [3:0]        lsu_errtp
);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic [31:0]       r_addr;
  logic [7:0]        r_rlen;
  logic [1:0]        r_mask;
  logic              r_sign;
  logic              r_burst;
  logic [LANE_W-1:0] r_wdata;
  logic              r_aw_done;
  logic              r_w_done;
  logic [7:0]        r_beat;

  logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic w_aw_ok, w_w_ok;

  assign w_ar_hs = arvalid & arready;
  assign w_r_hs  = rvalid & rready;
  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid & wready;
  assign w_b_hs  = bvalid & bready;
  assign w_aw_ok = r_aw_done | w_aw_hs;
  assign w_w_ok  = r_w_done | w_w_hs;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (lsu_rvalid)      w_next = ST_RADDR;
        else if (lsu_wvalid) w_next = ST_WREQ;
      end
      ST_RADDR: if (w_ar_hs) w_next = ST_RDATA;
      ST_RDATA: if (w_r_hs && rlast) w_next = ST_IDLE;
      ST_WREQ:  if (w_aw_ok && w_w_ok) w_next = ST_WRESP;
      ST_WRESP: if (w_b_hs) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    lsu_rready = 1'b0;
    lsu_wready = 1'b0;
    case (r_state)
      ST_RADDR: arvalid = 1'b1;
      ST_RDATA: begin
        rready     = 1'b1;
        lsu_rready = rvalid;
      end
      ST_WREQ: begin
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
      end
      ST_WRESP: begin
        bready     = 1'b1;
        lsu_wready = bvalid;
      end
      default: ;
    endcase
  end

  // Read and write share the address/mask latches; only one is in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr    <= '0;
      r_rlen    <= '0;
      r_mask    <= '0;
      r_sign    <= 1'b0;
      r_burst   <= 1'b0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_beat    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (lsu_rvalid) begin
            r_addr  <= lsu_raddr;
            r_rlen  <= lsu_burst ? lsu_rlen : 8'd0;
            r_mask  <= lsu_rmask;
            r_sign  <= lsu_rsign;
            r_burst <= lsu_burst;
          end else if (lsu_wvalid) begin
            r_addr  <= lsu_waddr;
            r_wdata <= lsu_wdata;
            r_mask  <= lsu_wmask;
            r_burst <= 1'b0;
          end
        end
        ST_RADDR: if (w_ar_hs) r_beat <= '0;
        ST_RDATA: if (w_r_hs) r_beat <= r_beat + 8'd1;
        ST_WREQ: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign araddr  = r_addr;
  assign arid    = '0;
  assign arlen   = r_rlen;
  assign arsize  = mask_to_size(r_mask, r_burst);
  assign arburst = AXI_BURST_INCR;
  assign awaddr  = r_addr;
  assign awid    = '0;
  assign awlen   = 8'd0;
  assign awsize  = mask_to_size(r_mask, 1'b0);
  assign awburst = AXI_BURST_INCR;
  assign wlast   = 1'b1;

  ysyx_25040111_lsu_align #(.LANE_W(LANE_W)) u_align (
    .i_rlo    (r_addr[1:0]),
    .i_rmask  (r_mask),
    .i_rsign  (r_sign),
    .i_rburst (r_burst),
    .i_rdata  (rdata),
    .o_rdata  (lsu_rdata),
    .i_wlo    (r_addr[1:0]),
    .i_wmask  (r_mask),
    .i_wdata  (r_wdata),
    .o_wdata  (wdata),
    .o_wstrb  (wstrb)
  );

`ifdef YSYX_25040111_LSU_RESP_CHK_EN
  logic w_rd_fault;
  logic w_wr_fault;

  // A faulting beat is still handed back; the fault rides alongside it.
  assign w_rd_fault = w_r_hs && ((rresp != AXI_RESP_OKAY) || (rid != '0) ||
                                 (rlast && (r_beat != r_rlen)));
  assign w_wr_fault = w_b_hs && ((bresp != AXI_RESP_OKAY) || (bid != '0));
  assign lsu_err    = w_rd_fault | w_wr_fault;
  assign lsu_errtp  = w_rd_fault ? ERR_LOAD_FAULT :
                      (w_wr_fault ? ERR_STORE_FAULT : 4'd0);
`else
  logic w_unused;
  assign w_unused  = ^{rresp, rid, bresp, bid, r_beat};
  assign lsu_err   = 1'b0;
  assign lsu_errtp = 4'd0;
`endif

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Scoreboard bench for ysyx_25040111_lsu: directed requests, AXI slave driven inline.
module tb_ysyx_25040111_lsu;
  localparam int ID_W = 4;

`ifdef YSYX_25040111_LSU_RESP_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clock, reset;
  logic lsu_rvalid, lsu_rready, lsu_burst, lsu_rsign;
  logic [31:0] lsu_raddr, lsu_rdata;
  logic [7:0] lsu_rlen;
  logic [1:0] lsu_rmask;
  logic lsu_wvalid, lsu_wready;
  logic [31:0] lsu_waddr, lsu_wdata;
  logic [1:0] lsu_wmask;
  logic awvalid, awready;
  logic [31:0] awaddr;
  logic [ID_W-1:0] awid;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic wvalid, wready, wlast;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic bvalid, bready;
  logic [1:0] bresp;
  logic [ID_W-1:0] bid;
  logic arvalid, arready;
  logic [31:0] araddr;
  logic [ID_W-1:0] arid;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic [ID_W-1:0] rid;
  logic lsu_err;
  logic [3:0] lsu_errtp;

  ysyx_25040111_lsu dut (
    .clock(clock), .reset(reset),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_raddr(lsu_raddr),
    .lsu_rlen(lsu_rlen), .lsu_burst(lsu_burst), .lsu_rsign(lsu_rsign),
    .lsu_rmask(lsu_rmask), .lsu_rdata(lsu_rdata),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_waddr(lsu_waddr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid),
    .lsu_err(lsu_err), .lsu_errtp(lsu_errtp)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [2:0] size;} ax_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb;} w_t;
  typedef struct packed {logic [31:0] data; logic err; logic [3:0] tp;} rsp_t;

  ax_t  q_ar[$], q_aw[$];
  w_t   q_w[$];
  rsp_t q_rd[$], q_wr[$];

  // Written only by the stimulus process; read by the monitor.
  logic chk_idle, chk_noaw, chk_lat, end_req;
  int   lat_meas, tmo_cnt;

  // Written only by the monitor.
  int   n_checks, n_errors;
  ax_t  e_ax;
  w_t   e_w;
  rsp_t e_rs;

  function automatic void push_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    ax_t e; e.addr = a; e.len = l; e.size = s; q_ar.push_back(e);
  endfunction
  function automatic void push_aw(input logic [31:0] a, input logic [2:0] s);
    ax_t e; e.addr = a; e.len = 8'd0; e.size = s; q_aw.push_back(e);
  endfunction
  function automatic void push_w(input logic [31:0] d, input logic [3:0] s);
    w_t e; e.data = d; e.strb = s; q_w.push_back(e);
  endfunction
  function automatic void push_rd(input logic [31:0] d, input logic [1:0] resp);
    rsp_t e; e.data = d; e.err = CHK && (resp != 2'b00); e.tp = e.err ? 4'd5 : 4'd0;
    q_rd.push_back(e);
  endfunction
  function automatic void push_wr(input logic [1:0] resp);
    rsp_t e; e.data = '0; e.err = CHK && (resp != 2'b00); e.tp = e.err ? 4'd7 : 4'd0;
    q_wr.push_back(e);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_idle)
      cmp("idle_outputs", 32'({arvalid, rready, awvalid, wvalid, bready,
                               lsu_rready, lsu_wready, lsu_err, lsu_errtp}), 32'd0);
    if (chk_noaw) cmp("no_aw_while_read", 32'(awvalid), 32'd0);
    if (chk_lat)  cmp("wr_after_rd_latency", 32'(lat_meas), 32'd1);
    if (arvalid && arready) begin
      if (q_ar.size() == 0) cmp("ar_unexpected", 32'd1, 32'd0);
      else begin
        e_ax = q_ar.pop_front();
        cmp("araddr", araddr, e_ax.addr);
        cmp("arlen", 32'(arlen), 32'(e_ax.len));
        cmp("arsize", 32'(arsize), 32'(e_ax.size));
        cmp("arburst_arid", 32'({arburst, arid}), 32'({2'b01, 4'd0}));
      end
    end
    if (awvalid && awready) begin
      if (q_aw.size() == 0) cmp("aw_unexpected", 32'd1, 32'd0);
      else begin
        e_ax = q_aw.pop_front();
        cmp("awaddr", awaddr, e_ax.addr);
        cmp("awsize", 32'(awsize), 32'(e_ax.size));
        cmp("awlen_burst", 32'({awlen, awburst}), 32'({8'd0, 2'b01}));
      end
    end
    if (wvalid && wready) begin
      if (q_w.size() == 0) cmp("w_unexpected", 32'd1, 32'd0);
      else begin
        e_w = q_w.pop_front();
        cmp("wdata", wdata, e_w.data);
        cmp("wstrb_wlast", 32'({wstrb, wlast}), 32'({e_w.strb, 1'b1}));
      end
    end
    if (lsu_rready) begin
      if (q_rd.size() == 0) cmp("lsu_rready_unexpected", 32'd1, 32'd0);
      else begin
        e_rs = q_rd.pop_front();
        cmp("lsu_rdata", lsu_rdata, e_rs.data);
        cmp("rd_err", 32'({lsu_err, lsu_errtp}), 32'({e_rs.err, e_rs.tp}));
      end
    end
    if (lsu_wready) begin
      if (q_wr.size() == 0) cmp("lsu_wready_unexpected", 32'd1, 32'd0);
      else begin
        e_rs = q_wr.pop_front();
        cmp("wready_with_b_hs", 32'(bvalid && bready), 32'd1);
        cmp("wr_err", 32'({lsu_err, lsu_errtp}), 32'({e_rs.err, e_rs.tp}));
      end
    end
    if (lsu_err && !lsu_rready && !lsu_wready) cmp("stray_lsu_err", 32'(lsu_err), 32'd0);
    if (end_req) begin
      cmp("queues_drained", 32'(q_ar.size() + q_aw.size() + q_w.size() + q_rd.size() + q_wr.size()), 32'd0);
      cmp("timeouts", 32'(tmo_cnt), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic logic sig(input int k);
    return (k == 0) ? arvalid : awvalid;
  endfunction

  task automatic wait_for(input int k, input string what, output int waited);
    waited = 0;
    while (!sig(k) && waited < 50) begin
      tick();
      waited++;
    end
    if (!sig(k)) begin
      tmo_cnt++;
      $display("FAIL timeout %s: waited %0d cycles, limit 50", what, waited);
    end
  endtask

  task automatic rd_req(input logic [31:0] a, input logic [7:0] l, input logic b,
                        input logic s, input logic [1:0] m);
    lsu_rvalid = 1'b1; lsu_raddr = a; lsu_rlen = l; lsu_burst = b; lsu_rsign = s; lsu_rmask = m;
  endtask

  task automatic ar_phase(input int d);
    int w;
    wait_for(0, "arvalid", w);
    repeat (d) tick();
    arready = 1'b1; tick(); arready = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] d, input logic last, input logic [1:0] resp, input int gap);
    repeat (gap) tick();
    rvalid = 1'b1; rdata = d; rlast = last; rresp = resp;
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    lsu_wvalid = 1'b1; lsu_waddr = a; lsu_wdata = d; lsu_wmask = m;
  endtask

  task automatic wr_phase(input int aw_d, input int w_d, input int b_d,
                          input logic [1:0] resp, output int lat);
    int last;
    wait_for(1, "awvalid", lat);
    last = (aw_d > w_d) ? aw_d : w_d;
    for (int c = 0; c <= last; c++) begin
      awready = (c == aw_d); wready = (c == w_d);
      tick();
    end
    awready = 1'b0; wready = 1'b0;
    repeat (b_d) tick();
    bvalid = 1'b1; bresp = resp;
    tick();
    bvalid = 1'b0; bresp = 2'b00; lsu_wvalid = 1'b0;
  endtask

  initial begin
    int lat;
    n_checks = 0; n_errors = 0; tmo_cnt = 0; lat_meas = 0;
    chk_idle = 0; chk_noaw = 0; chk_lat = 0; end_req = 0;
    reset = 1'b1;
    lsu_rvalid = 0; lsu_raddr = 0; lsu_rlen = 0; lsu_burst = 0; lsu_rsign = 0; lsu_rmask = 0;
    lsu_wvalid = 0; lsu_waddr = 0; lsu_wdata = 0; lsu_wmask = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    repeat (2) tick();
    chk_idle = 1; tick(); reset = 1'b0; tick(); chk_idle = 0;

    // Signed byte at lane 3; rlen ignored without burst.
    rd_req(32'h8000_0003, 8'd7, 1'b0, 1'b1, 2'b00);
    push_ar(32'h8000_0003, 8'd0, 3'd0); push_rd(32'hFFFF_FF80, 2'b00);
    ar_phase(0); r_beat(32'h80AB_CDEF, 1'b1, 2'b00, 0); lsu_rvalid = 0; tick();

    // Unsigned half at lane 2.
    rd_req(32'h8000_0002, 8'd0, 1'b0, 1'b0, 2'b01);
    push_ar(32'h8000_0002, 8'd0, 3'd1); push_rd(32'h0000_9234, 2'b00);
    ar_phase(1); r_beat(32'h9234_5678, 1'b1, 2'b00, 1); lsu_rvalid = 0; tick();

    // Burst refill: data must pass unmodified despite byte mask + sign.
    rd_req(32'h3000_0000, 8'd3, 1'b1, 1'b1, 2'b00);
    push_ar(32'h3000_0000, 8'd3, 3'd2);
    push_rd(32'h1111_1111, 2'b00); push_rd(32'hDEAD_BEEF, 2'b00);
    push_rd(32'h8000_0001, 2'b00); push_rd(32'h0000_FFFF, 2'b00);
    ar_phase(2);
    r_beat(32'h1111_1111, 1'b0, 2'b00, 0);
    r_beat(32'hDEAD_BEEF, 1'b0, 2'b00, 2);
    r_beat(32'h8000_0001, 1'b0, 2'b00, 1);
    r_beat(32'h0000_FFFF, 1'b1, 2'b00, 3);
    lsu_rvalid = 0; chk_idle = 1; tick(); chk_idle = 0;

    // Signed half lane 0, unsigned byte lane 1, reserved mask as word.
    rd_req(32'h8000_0010, 8'd0, 1'b0, 1'b1, 2'b01);
    push_ar(32'h8000_0010, 8'd0, 3'd1); push_rd(32'hFFFF_8001, 2'b00);
    ar_phase(0); r_beat(32'h1234_8001, 1'b1, 2'b00, 0); lsu_rvalid = 0; tick();
    rd_req(32'h8000_0011, 8'd0, 1'b0, 1'b0, 2'b00);
    push_ar(32'h8000_0011, 8'd0, 3'd0); push_rd(32'h0000_0080, 2'b00);
    ar_phase(0); r_beat(32'h1234_8001, 1'b1, 2'b00, 0); lsu_rvalid = 0; tick();
    rd_req(32'h8000_0016, 8'd0, 1'b0, 1'b1, 2'b10);
    push_ar(32'h8000_0016, 8'd0, 3'd2); push_rd(32'hA1B2_C3D4, 2'b00);
    ar_phase(0); r_beat(32'hA1B2_C3D4, 1'b1, 2'b00, 0); lsu_rvalid = 0; tick();

    // Byte write lane 2: awready a cycle before wready, bvalid 3 cycles later.
    wr_req(32'h1000_0002, 32'h0000_00A5, 2'b00);
    push_aw(32'h1000_0002, 3'd0); push_w(32'h00A5_0000, 4'b0100); push_wr(2'b00);
    wr_phase(0, 1, 3, 2'b00, lat); tick();

    // Half lane 1, misaligned half lane 3 (truncated), word.
    wr_req(32'h1000_0005, 32'h0000_BEEF, 2'b01);
    push_aw(32'h1000_0005, 3'd1); push_w(32'h00BE_EF00, 4'b0110); push_wr(2'b00);
    wr_phase(1, 0, 0, 2'b00, lat); tick();
    wr_req(32'h1000_0007, 32'h0000_BEEF, 2'b01);
    push_aw(32'h1000_0007, 3'd1); push_w(32'hEF00_0000, 4'b1000); push_wr(2'b00);
    wr_phase(0, 0, 1, 2'b00, lat); tick();
    wr_req(32'h1000_0008, 32'h1234_5678, 2'b11);
    push_aw(32'h1000_0008, 3'd2); push_w(32'h1234_5678, 4'b1111); push_wr(2'b00);
    wr_phase(2, 2, 0, 2'b00, lat); tick();

    // Simultaneous read and write: read first, write right after.
    wr_req(32'h2000_0004, 32'h55AA_55AA, 2'b11);
    rd_req(32'h2000_0000, 8'd0, 1'b0, 1'b0, 2'b11);
    push_ar(32'h2000_0000, 8'd0, 3'd2); push_rd(32'hCAFE_F00D, 2'b00);
    push_aw(32'h2000_0004, 3'd2); push_w(32'h55AA_55AA, 4'b1111); push_wr(2'b00);
    ar_phase(1);
    chk_noaw = 1; r_beat(32'hCAFE_F00D, 1'b1, 2'b00, 1); chk_noaw = 0;
    lsu_rvalid = 0;
    wr_phase(0, 0, 0, 2'b00, lat);
    lat_meas = lat; chk_lat = 1; tick(); chk_lat = 0;

    // Reset while waiting in RDATA.
    rd_req(32'h4000_0000, 8'd0, 1'b0, 1'b0, 2'b11);
    push_ar(32'h4000_0000, 8'd0, 3'd2);
    ar_phase(0); tick();
    reset = 1'b1; lsu_rvalid = 0; tick(); reset = 1'b0;
    chk_idle = 1; tick(); chk_idle = 0;

    // Error responses (fault reported only with response checking built in).
    rd_req(32'h5000_0000, 8'd0, 1'b0, 1'b0, 2'b11);
    push_ar(32'h5000_0000, 8'd0, 3'd2); push_rd(32'h0123_4567, 2'b10);
    ar_phase(0); r_beat(32'h0123_4567, 1'b1, 2'b10, 0); lsu_rvalid = 0; tick();
    wr_req(32'h5000_0008, 32'hDEAD_BEEF, 2'b11);
    push_aw(32'h5000_0008, 3'd2); push_w(32'hDEAD_BEEF, 4'b1111); push_wr(2'b10);
    wr_phase(0, 0, 2, 2'b10, lat); tick();

    repeat (3) tick();
    end_req = 1;
    repeat (5) tick();
  end

endmodule
